datapath_seq: RTL and testbench

//  Parametrised, self-sequencing successor to the 16-bit register-file/ALU datapath.

---
 rtl/datapath_seq_if.sv | 36 +++
 rtl/datapath_seq.sv | 159 +++++++++++++++
 tb/tb_datapath_seq.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_seq_if.sv
// Command/response bundle for datapath_seq: one command in, status and result out.
// The master issues commands; the slave (the datapath) sequences and reports back.
interface datapath_seq_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
);
    localparam int RA = $clog2(NREGS);

    logic             start;
    logic [RA-1:0]    rn;
    logic [RA-1:0]    rm;
    logic [RA-1:0]    rd;
    logic [1:0]       shift;
    logic [1:0]       ALUop;
    logic             asel;
    logic             bsel;
    logic             vsel;
    logic             loads;
    logic             write;
    logic [WIDTH-1:0] datapath_in;

    logic             busy;
    logic             done;
    logic [2:0]       status;
    logic [WIDTH-1:0] datapath_out;

    modport master (
        output start, rn, rm, rd, shift, ALUop, asel, bsel, vsel, loads, write, datapath_in,
        input  busy, done, status, datapath_out
    );

    modport slave (
        input  start, rn, rm, rd, shift, ALUop, asel, bsel, vsel, loads, write, datapath_in,
        output busy, done, status, datapath_out
    );
endinterface

// File: rtl/datapath_seq.sv
// Register-file/ALU datapath driven by a 4-step micro-sequencer (read A, read B, execute, writeback).
// One command is captured per start in IDLE; everything else on the bus is ignored until it completes.
module datapath_seq #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic            clk,
    input  logic            reset,
    datapath_seq_if.slave   bus
);
    localparam int RA = $clog2(NREGS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RDA,
        S_RDB,
        S_EXEC,
        S_WB
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_MVN = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic [RA-1:0]    rn;
        logic [RA-1:0]    rm;
        logic [RA-1:0]    rd;
        logic [1:0]       shift;
        logic [1:0]       alu_op;
        logic             asel;
        logic             bsel;
        logic             vsel;
        logic             loads;
        logic             write;
        logic [WIDTH-1:0] imm;
    } cmd_t;

    state_e           state_q;
    cmd_t             cmd_q;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] c_q;
    logic [2:0]       status_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] ain;
    logic [WIDTH-1:0] bsh;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] res_d;
    logic             ovf;
    logic [2:0]       flags_d;

    // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        ain = cmd_q.asel ? '0 : a_q;
        bsh = b_q;
        ovf = 1'b0;
        res_d = '0;

        case (cmd_q.shift)
            2'b01:   bsh = {b_q[WIDTH-2:0], 1'b0};
            2'b10:   bsh = {1'b0, b_q[WIDTH-1:1]};
            2'b11:   bsh = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
            default: bsh = b_q;
        endcase

        bin = cmd_q.bsel ? cmd_q.imm : bsh;

        // Overflow: operands of the effective same sign produce a result of the other sign.
        case (alu_op_e'(cmd_q.alu_op))
            OP_ADD: begin
                res_d = ain + bin;
                ovf   = (ain[WIDTH-1] == bin[WIDTH-1]) && (res_d[WIDTH-1] != ain[WIDTH-1]);
            end
            OP_SUB: begin
                res_d = ain + ~bin + WIDTH'(1);
                ovf   = (ain[WIDTH-1] != bin[WIDTH-1]) && (res_d[WIDTH-1] != ain[WIDTH-1]);
            end
            OP_AND:  res_d = ain & bin;
            default: res_d = ~bin;
        endcase

        flags_d = {ovf, res_d[WIDTH-1], (res_d == '0)};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cmd_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            status_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            // NOTE: the register file is a small flop array, so it is cleared by reset like any other state.
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        cmd_q.rn     <= bus.rn;
                        cmd_q.rm     <= bus.rm;
                        cmd_q.rd     <= bus.rd;
                        cmd_q.shift  <= bus.shift;
                        cmd_q.alu_op <= bus.ALUop;
                        cmd_q.asel   <= bus.asel;
                        cmd_q.bsel   <= bus.bsel;
                        cmd_q.vsel   <= bus.vsel;
                        cmd_q.loads  <= bus.loads;
                        cmd_q.write  <= bus.write;
                        cmd_q.imm    <= bus.datapath_in;
                        busy_q       <= 1'b1;
                        state_q      <= S_RDA;
                    end
                end
                S_RDA: begin
                    a_q     <= regs_q[cmd_q.rn];
                    state_q <= S_RDB;
                end
                S_RDB: begin
                    b_q     <= regs_q[cmd_q.rm];
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    c_q <= res_d;
                    if (cmd_q.loads) begin
                        status_q <= flags_d;
                    end
                    state_q <= S_WB;
                end
                S_WB: begin
                    if (cmd_q.write) begin
                        regs_q[cmd_q.rd] <= cmd_q.vsel ? cmd_q.imm : c_q;
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.status       = status_q;
    assign bus.datapath_out = c_q;
endmodule

// File: tb/tb_datapath_seq.sv
// Drives three datapath_seq configurations (16/8, 8/4, 32/16) with identical command streams
// and compares each against a width-generic arithmetic model of the datapath.
module tb_datapath_seq;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Shared command drivers, truncated per configuration.
    logic             s_start;
    logic [3:0]       s_rn, s_rm, s_rd;
    logic [1:0]       s_shift, s_op;
    logic             s_asel, s_bsel, s_vsel, s_loads, s_write;
    logic [31:0]      s_din [3];

    datapath_seq_if #(.WIDTH(16), .NREGS(8))  b16 ();
    datapath_seq_if #(.WIDTH(8),  .NREGS(4))  b8  ();
    datapath_seq_if #(.WIDTH(32), .NREGS(16)) b32 ();

    datapath_seq #(.WIDTH(16), .NREGS(8))  u16 (.clk(clk), .reset(reset), .bus(b16));
    datapath_seq #(.WIDTH(8),  .NREGS(4))  u8  (.clk(clk), .reset(reset), .bus(b8));
    datapath_seq #(.WIDTH(32), .NREGS(16)) u32 (.clk(clk), .reset(reset), .bus(b32));

    assign b16.start = s_start;   assign b8.start = s_start;   assign b32.start = s_start;
    assign b16.rn = s_rn[2:0];    assign b8.rn = s_rn[1:0];    assign b32.rn = s_rn;
    assign b16.rm = s_rm[2:0];    assign b8.rm = s_rm[1:0];    assign b32.rm = s_rm;
    assign b16.rd = s_rd[2:0];    assign b8.rd = s_rd[1:0];    assign b32.rd = s_rd;
    assign b16.shift = s_shift;   assign b8.shift = s_shift;   assign b32.shift = s_shift;
    assign b16.ALUop = s_op;      assign b8.ALUop = s_op;      assign b32.ALUop = s_op;
    assign b16.asel = s_asel;     assign b8.asel = s_asel;     assign b32.asel = s_asel;
    assign b16.bsel = s_bsel;     assign b8.bsel = s_bsel;     assign b32.bsel = s_bsel;
    assign b16.vsel = s_vsel;     assign b8.vsel = s_vsel;     assign b32.vsel = s_vsel;
    assign b16.loads = s_loads;   assign b8.loads = s_loads;   assign b32.loads = s_loads;
    assign b16.write = s_write;   assign b8.write = s_write;   assign b32.write = s_write;
    assign b16.datapath_in = s_din[0][15:0];
    assign b8.datapath_in  = s_din[1][7:0];
    assign b32.datapath_in = s_din[2];

    logic [63:0] obs_out  [3];
    logic [2:0]  obs_stat [3];
    logic        obs_busy [3];
    logic        obs_done [3];
    assign obs_out[0] = 64'(b16.datapath_out);
    assign obs_out[1] = 64'(b8.datapath_out);
    assign obs_out[2] = 64'(b32.datapath_out);
    assign obs_stat[0] = b16.status;  assign obs_stat[1] = b8.status;  assign obs_stat[2] = b32.status;
    assign obs_busy[0] = b16.busy;    assign obs_busy[1] = b8.busy;    assign obs_busy[2] = b32.busy;
    assign obs_done[0] = b16.done;    assign obs_done[1] = b8.done;    assign obs_done[2] = b32.done;

    int cfg_w  [3] = '{16, 8, 32};
    int cfg_nr [3] = '{8, 4, 16};

    typedef struct {
        int               rn, rm, rd, shift, op;
        bit               asel, bsel, vsel, loads, write;
        logic [2:0][31:0] din;
    } cmd_t;

    // Reference state: plain integers per configuration.
    longint unsigned m_reg  [3][16];
    longint unsigned m_c    [3];
    logic [2:0]      m_stat [3];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint unsigned mask_of(int k);
        return (64'd1 << cfg_w[k]) - 64'd1;
    endfunction

    function automatic longint to_signed(int k, longint unsigned x);
        longint unsigned half = 64'd1 << (cfg_w[k] - 1);
        return (x >= half) ? longint'(x) - longint'(half << 1) : longint'(x);
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 16; r++) m_reg[k][r] = 0;
            m_c[k]    = 0;
            m_stat[k] = 3'b000;
        end
    endfunction

    function automatic void model_apply(int k, cmd_t c);
        longint unsigned m    = mask_of(k);
        longint unsigned half = 64'd1 << (cfg_w[k] - 1);
        longint unsigned din  = 64'(c.din[k]) & m;
        longint unsigned a, b, bsh, bin, res;
        longint          s;
        bit              v = 1'b0;

        a = c.asel ? 0 : m_reg[k][c.rn % cfg_nr[k]];
        b = m_reg[k][c.rm % cfg_nr[k]];
        case (c.shift)
            0:       bsh = b;
            1:       bsh = (b * 2) & m;
            2:       bsh = b / 2;
            default: bsh = b / 2 + ((b >= half) ? half : 0);
        endcase
        bin = c.bsel ? din : bsh;
        case (c.op)
            0: begin
                res = (a + bin) & m;
                s   = to_signed(k, a) + to_signed(k, bin);
                v   = (s > longint'(half) - 1) || (s < -longint'(half));
            end
            1: begin
                res = (a + (m + 1) - bin) & m;
                s   = to_signed(k, a) - to_signed(k, bin);
                v   = (s > longint'(half) - 1) || (s < -longint'(half));
            end
            2:       res = a & bin;
            default: res = ~bin & m;
        endcase
        if (c.loads) m_stat[k] = {v, (res >= half), (res == 0)};
        m_c[k] = res;
        if (c.write) m_reg[k][c.rd % cfg_nr[k]] = c.vsel ? din : res;
    endfunction

    function automatic cmd_t mk(int rn, int rm, int rd, int shift, int op,
                                bit asel, bit bsel, bit vsel, bit loads, bit write,
                                logic [31:0] d16, logic [31:0] d8, logic [31:0] d32);
        cmd_t c;
        c.rn = rn; c.rm = rm; c.rd = rd; c.shift = shift; c.op = op;
        c.asel = asel; c.bsel = bsel; c.vsel = vsel; c.loads = loads; c.write = write;
        c.din[0] = d16; c.din[1] = d8; c.din[2] = d32;
        return c;
    endfunction

    task automatic drive(input cmd_t c);
        s_rn = 4'(c.rn); s_rm = 4'(c.rm); s_rd = 4'(c.rd);
        s_shift = 2'(c.shift); s_op = 2'(c.op);
        s_asel = c.asel; s_bsel = c.bsel; s_vsel = c.vsel; s_loads = c.loads; s_write = c.write;
        for (int k = 0; k < 3; k++) s_din[k] = c.din[k];
    endtask

    task automatic scramble();
        s_rn = 4'($urandom); s_rm = 4'($urandom); s_rd = 4'($urandom);
        s_shift = 2'($urandom); s_op = 2'($urandom);
        s_asel = 1'($urandom); s_bsel = 1'($urandom); s_vsel = 1'($urandom);
        s_loads = 1'($urandom); s_write = 1'($urandom);
        for (int k = 0; k < 3; k++) s_din[k] = $urandom;
    endtask

    // Issue one command and follow it to its done cycle; returns in that cycle so the next
    // command can be offered there. With glitch set, start is re-pulsed while in RDB.
    task automatic run_cmd(input string tag, input cmd_t c, input bit glitch);
        drive(c);
        s_start = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            @(posedge clk); #1;
            s_start = 1'b0;
            if (i == 0) scramble();
            if (glitch && i == 1) s_start = 1'b1;
            for (int k = 0; k < 3; k++) begin
                check($sformatf("%s busy c%0d w%0d", tag, i, cfg_w[k]), 64'(obs_busy[k]), (i < 4) ? 1 : 0);
                check($sformatf("%s done c%0d w%0d", tag, i, cfg_w[k]), 64'(obs_done[k]), (i == 4) ? 1 : 0);
                if (i == 2) check($sformatf("%s C held w%0d", tag, cfg_w[k]), obs_out[k], m_c[k]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            model_apply(k, c);
            check($sformatf("%s out w%0d", tag, cfg_w[k]), obs_out[k], m_c[k]);
            check($sformatf("%s status w%0d", tag, cfg_w[k]), 64'(obs_stat[k]), 64'(m_stat[k]));
        end
        if (glitch) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                check($sformatf("%s dropped busy w%0d", tag, cfg_w[k]), 64'(obs_busy[k]), 0);
                check($sformatf("%s dropped done w%0d", tag, cfg_w[k]), 64'(obs_done[k]), 0);
            end
        end
    endtask

    // Reads register n onto datapath_out: 0 + R[n], no writeback, status untouched.
    task automatic read_reg(input int n);
        run_cmd($sformatf("rd R%0d", n), mk(0, n, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    endtask

    task automatic mov(input int rd, input logic [31:0] d16, input logic [31:0] d8, input logic [31:0] d32);
        run_cmd($sformatf("mov R%0d", rd), mk(0, 0, rd, 0, 0, 0, 0, 1, 0, 1, d16, d8, d32), 1'b0);
    endtask

    task automatic abort_in_exec(input cmd_t c);
        drive(c);
        s_start = 1'b1;
        @(posedge clk); #1;        // captured, RDA
        s_start = 1'b0;
        @(posedge clk); #1;        // RDB
        @(posedge clk); #1;        // EXEC
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("abort busy w%0d", cfg_w[k]), 64'(obs_busy[k]), 0);
            check($sformatf("abort done w%0d", cfg_w[k]), 64'(obs_done[k]), 0);
            check($sformatf("abort out w%0d", cfg_w[k]), obs_out[k], 0);
            check($sformatf("abort status w%0d", cfg_w[k]), 64'(obs_stat[k]), 0);
        end
        read_reg(c.rd);
    endtask

    initial begin
        cmd_t c;
        s_start = 1'b0;
        scramble();
        reset = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset busy w%0d", cfg_w[k]), 64'(obs_busy[k]), 0);
            check($sformatf("reset done w%0d", cfg_w[k]), 64'(obs_done[k]), 0);
            check($sformatf("reset out w%0d", cfg_w[k]), obs_out[k], 0);
            check($sformatf("reset status w%0d", cfg_w[k]), 64'(obs_stat[k]), 0);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int n = 0; n < 16; n++) read_reg(n);

        // MOV / ADD / SUB basics
        mov(1, 7, 7, 7);
        mov(2, 5, 5, 5);
        run_cmd("add R3", mk(1, 2, 3, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), 1'b0);
        check("add R3 literal", obs_out[0], 64'd12);
        check("add R3 flags literal", 64'(obs_stat[0]), 64'd0);
        run_cmd("sub R4", mk(2, 1, 4, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0), 1'b0);
        check("sub R4 literal", obs_out[0], 64'hFFFE);
        check("sub R4 flags literal", 64'(obs_stat[0]), 64'b010);
        run_cmd("sub R1-R1", mk(1, 1, 5, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0), 1'b0);
        check("sub zero flags literal", 64'(obs_stat[0]), 64'b001);
        read_reg(3);
        read_reg(4);

        // Signed overflow: max positive + 1
        mov(6, 32'h7FFF, 32'h7F, 32'h7FFF_FFFF);
        run_cmd("add ovf", mk(6, 0, 7, 0, 0, 0, 1, 0, 1, 1, 1, 1, 1), 1'b0);
        check("add ovf literal", obs_out[0], 64'h8000);
        check("add ovf flags literal", 64'(obs_stat[0]), 64'b110);

        // ASR1 of the most negative value
        mov(1, 32'h8000, 32'h80, 32'h8000_0000);
        run_cmd("asr1", mk(0, 1, 2, 3, 0, 1, 0, 0, 0, 1, 0, 0, 0), 1'b0);
        check("asr1 literal", obs_out[0], 64'hC000);

        // Wrap to zero: all-ones + 1
        mov(1, 32'hFFFF, 32'hFF, 32'hFFFF_FFFF);
        run_cmd("add wrap", mk(1, 0, 3, 0, 0, 0, 1, 0, 1, 1, 1, 1, 1), 1'b0);
        check("add wrap w8 literal", obs_out[1], 64'd0);
        check("add wrap flags w8 literal", 64'(obs_stat[1]), 64'b001);

        // loads=0 keeps status, write=0 leaves the file alone
        run_cmd("nolds", mk(2, 1, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        read_reg(2);

        // start re-pulsed during RDB is dropped
        run_cmd("glitch", mk(2, 2, 2, 2, 0, 0, 0, 0, 1, 1, 0, 0, 0), 1'b1);
        read_reg(2);

        // reset in EXEC aborts the writeback
        mov(5, 32'h1234, 32'h34, 32'h1234_5678);
        abort_in_exec(mk(5, 5, 5, 0, 0, 0, 0, 1, 1, 1, 32'hAAAA, 32'hAA, 32'hAAAA_AAAA));

        // Randomized command stream
        for (int t = 0; t < 200; t++) begin
            c = mk($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   $urandom, $urandom, $urandom);
            run_cmd($sformatf("rnd%0d", t), c, ($urandom_range(0, 15) == 0));
        end
        for (int n = 0; n < 16; n++) read_reg(n);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
